li_immediate_encoder: RTL
=========================

// Module: li_immediate_encoder
// PURPOSE
//  Encoding counterpart of the immediate generator: expands a load-immediate request
//  (rd, 32-bit constant) into the RV32I sequence LUI rd,hi ; ADDI rd,rd,lo.
//  Sits between the boot/debug loader and the instruction memory write port.
//  Valid/ready on both sides; one instruction word emitted per output handshake.
// PARAMETERS
//  LUI_OPCODE   7'b0110111  opcode field of the emitted LUI
//  ADDI_OPCODE  7'b0010011  opcode field of the emitted ADDI (funct3 = 3'b000)
// PORTS
//  CLK        in   1   single clock, all state on rising edge
//  RESET_N    in   1   reset, asynchronous, active-low
//  REQ_VALID  in   1   request valid
//  REQ_READY  out  1   encoder can accept a request (high only in IDLE)
//  REQ_RD     in   5   destination register index
//  REQ_VALUE  in   32  constant to load
//  OUT_VALID  out  1   OUT_INSTR holds a valid instruction word
//  OUT_READY  in   1   consumer accepts OUT_INSTR
//  OUT_INSTR  out  32  encoded instruction word
//  OUT_LAST   out  1   high on the final word of the current sequence
// BEHAVIOUR
//  - Reset (async, RESET_N=0): state=IDLE, REQ_READY=1, OUT_VALID=0, OUT_INSTR=0,
//    OUT_LAST=0, captured rd/value regs=0. Any sequence in flight is dropped.
//  - All outputs are registered; no combinational path from REQ_* or OUT_READY to outputs.
//  - States: IDLE, EMIT_LUI, EMIT_ADDI.
//  - IDLE: REQ_VALID&&REQ_READY captures REQ_RD/REQ_VALUE -> EMIT_LUI next cycle,
//    REQ_READY=0. Accept in cycle N => first word valid in cycle N+1.
//  - hi[19:0] = (VALUE + 32'h800)[31:12], modulo 2^32 (wrap allowed);
//    lo[11:0] = VALUE[11:0]. Guarantees (hi<<12) + sext(lo) == VALUE mod 2^32.
//  - LUI word  = {hi, rd, LUI_OPCODE}; OUT_LAST=0.
//  - ADDI word = {lo, rd, 3'b000, rd, ADDI_OPCODE}; OUT_LAST=1.
//  - EMIT_LUI: OUT_VALID=1; on OUT_READY -> EMIT_ADDI (ADDI word presented next cycle).
//  - EMIT_ADDI: OUT_VALID=1; on OUT_READY -> IDLE: OUT_VALID=0, REQ_READY=1 next cycle.
//  - Backpressure: while OUT_VALID && !OUT_READY, OUT_INSTR/OUT_LAST held stable.
//  - Minimum 3 cycles per request (IDLE, LUI, ADDI); no request overlap.
//  - rd=0 is legal and encoded as-is (architectural no-op).
//  - REQ_VALID while REQ_READY=0 is ignored; REQ_* may change freely.
// CONFIGURATION
//  LI_SHORT_EN defined: shortest sequence emitted, checked in this order:
//    (a) VALUE[31:11] all equal -> single ADDI {lo, 5'd0, 3'b000, rd, ADDI_OPCODE},
//        rs1=x0, OUT_LAST=1 (covers VALUE=0);
//    (b) VALUE[11:0]==0 -> single LUI {VALUE[31:12], rd, LUI_OPCODE}, OUT_LAST=1;
//    (c) otherwise the normal LUI+ADDI pair. Minimum 2 cycles per short request.
//  LI_SHORT_EN undefined: always LUI+ADDI pair, exactly as in BEHAVIOUR.
// TESTING
//  1. rd=5, VALUE=32'h12345678, OUT_READY=1 -> 32'h123452B7 (LAST=0), then
//     32'h67828293 (LAST=1); REQ_READY back high 3 cycles after accept.
//  2. rd=1, VALUE=32'hFFFFF800 -> hi wraps to 0: 32'h000000B7, then 32'h80008093;
//     with LI_SHORT_EN -> single 32'h80000093, LAST=1.
//  3. rd=10, VALUE=32'h00000FFF (rounding) -> 32'h00001537, then 32'hFFF50513.
//  4. Hold OUT_READY=0 3 cycles in EMIT_LUI with REQ_VALID=1 -> OUT_INSTR stable,
//     REQ_READY=0, no second accept; release -> sequence completes unchanged.
//  5. Pull RESET_N low mid EMIT_ADDI -> OUT_VALID=0, REQ_READY=1 immediately;
//     next request (test 1 values) emits both words correctly.
//  6. LI_SHORT_EN, rd=5, VALUE=32'h12345000 -> single 32'h123452B7 with LAST=1;
//     VALUE=0 -> single 32'h00000293.

Source files
------------

// File: rtl/li_immediate_encoder.sv
// li_immediate_encoder
//
// Expands a load-immediate request (rd, 32-bit constant) into the RV32I pair
//   LUI  rd, hi
//   ADDI rd, rd, lo
// and presents one instruction word per output handshake.
//
// Because ADDI sign-extends its 12-bit immediate, hi is taken from VALUE + 0x800.
// This ensures that (hi << 12) + sext(lo) reproduces VALUE modulo 2^32.
//
// Optional build macro LI_SHORT_EN selects the shortest sequence:
//   - A single ADDI from x0 when VALUE fits in a signed 12-bit immediate.
//   - A single LUI when VALUE[11:0] is zero.
//   - Otherwise the normal pair.
//
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_ni       asynchronous active-low reset
//   req_valid_i  request valid
//   req_ready_o  request can be accepted (high only when idle)
//   req_rd_i     destination register index
//   req_value_i  constant to load
//   out_valid_o  out_instr_o holds a valid instruction word
//   out_ready_i  consumer accepts out_instr_o
//   out_instr_o  encoded instruction word
//   out_last_o   final word of the current sequence
//
// All outputs come straight from registers.
module li_immediate_encoder #(
  parameter logic [6:0] LUI_OPCODE  = 7'b0110111,
  parameter logic [6:0] ADDI_OPCODE = 7'b0010011
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [4:0]  req_rd_i,
  input  logic [31:0] req_value_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic        out_last_o
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StEmitLui  = 2'd1;
  // Also used as "emitting the final word" for single-word short sequences.
  localparam logic [1:0] StEmitAddi = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] value_q, value_d;
  logic        req_ready_q, req_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_last_q, out_last_d;

  logic [31:0] req_rounded;

  function automatic logic [31:0] lui_word(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, LUI_OPCODE};
  endfunction

  function automatic logic [31:0] addi_word(input logic [11:0] imm, input logic [4:0] rs1,
                                            input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, ADDI_OPCODE};
  endfunction

  // Upper part rounded so the sign-extended low 12 bits cancel out; wraps mod 2^32.
  assign req_rounded = req_value_i + 32'h0000_0800;

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    value_d     = value_q;
    req_ready_d = req_ready_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_last_d  = out_last_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i && req_ready_q) begin
          rd_d        = req_rd_i;
          value_d     = req_value_i;
          req_ready_d = 1'b0;
          out_valid_d = 1'b1;
`ifdef LI_SHORT_EN
          if ((&req_value_i[31:11]) || !(|req_value_i[31:11])) begin
            // Fits a signed 12-bit immediate: ADDI rd, x0, lo.
            state_d     = StEmitAddi;
            out_instr_d = addi_word(req_value_i[11:0], 5'd0, req_rd_i);
            out_last_d  = 1'b1;
          end else if (req_value_i[11:0] == 12'd0) begin
            state_d     = StEmitAddi;
            out_instr_d = lui_word(req_value_i[31:12], req_rd_i);
            out_last_d  = 1'b1;
          end else begin
            state_d     = StEmitLui;
            out_instr_d = lui_word(req_rounded[31:12], req_rd_i);
            out_last_d  = 1'b0;
          end
`else
          state_d     = StEmitLui;
          out_instr_d = lui_word(req_rounded[31:12], req_rd_i);
          out_last_d  = 1'b0;
`endif
        end
      end
      StEmitLui: begin
        if (out_ready_i) begin
          state_d     = StEmitAddi;
          out_instr_d = addi_word(value_q[11:0], rd_q, rd_q);
          out_last_d  = 1'b1;
        end
      end
      StEmitAddi: begin
        if (out_ready_i) begin
          state_d     = StIdle;
          req_ready_d = 1'b1;
          out_valid_d = 1'b0;
          out_instr_d = 32'd0;
          out_last_d  = 1'b0;
        end
      end
      default: begin
        state_d     = StIdle;
        req_ready_d = 1'b1;
        out_valid_d = 1'b0;
        out_instr_d = 32'd0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      rd_q        <= 5'd0;
      value_q     <= 32'd0;
      req_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      value_q     <= value_d;
      req_ready_q <= req_ready_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_last_q  <= out_last_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_instr_o = out_instr_q;
  assign out_last_o  = out_last_q;

endmodule
